// File: rtl/adder_bist_pkg.sv
// Shared types, widths and the reference adder function for the adder BIST engine.
package adder_bist_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned VEC_W     = 2 * DEF_WIDTH + 1;
    localparam int unsigned ERR_W     = 2 * DEF_WIDTH + 2;
    // Widest operand golden_sum accepts; callers zero-extend narrower operands.
    localparam int unsigned MAX_W     = 16;
    // Settle counter width; SETTLE_CYCLES is limited to 1..15.
    localparam int unsigned WAIT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } bist_state_e;

    // Full-precision a + b + cin; the extra bit is the carry out.
    function automatic logic [MAX_W:0] golden_sum(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             cin
    );
        golden_sum = {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_4bit_bist_vec_gen.sv
// Vector counter, settle wait counter and last-vector flag for the BIST sweep.
module bist_vec_gen
    import adder_bist_pkg::*;
#(
    parameter int unsigned VW            = VEC_W,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic          dec_wait,
    output logic [VW-1:0] vec,
    output logic          wait_zero,
    output logic          last_vec
);

    localparam logic [WAIT_W-1:0] RELOAD = WAIT_W'(SETTLE_CYCLES - 1);

    logic [VW-1:0]     vec_q, vec_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Next vector / wait value: clear beats advance beats decrement.
    always_comb begin
        vec_d  = vec_q;
        wait_d = wait_q;
        if (clear) begin
            vec_d  = '0;
            wait_d = RELOAD;
        end else if (advance) begin
            vec_d  = vec_q + VW'(1);
            wait_d = RELOAD;
        end else if (dec_wait) begin
            wait_d = wait_q - WAIT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q  <= '0;
            wait_q <= '0;
        end else begin
            vec_q  <= vec_d;
            wait_q <= wait_d;
        end
    end

    assign vec       = vec_q;
    assign wait_zero = (wait_q == '0);
    assign last_vec  = (vec_q == '1);

endmodule

// File: rtl/adder_4bit_bist.sv
// Exhaustive self-test sweep for an adder: drives {cin,a,b}, checks {cout,sum}.
module adder_4bit_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               cin_out,
    input  logic [WIDTH-1:0]   sum_in,
    input  logic               cout_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] err_count,
    output logic [2*WIDTH:0]   first_fail,
    output logic               fail_seen
);

    localparam int unsigned VW = 2 * WIDTH + 1;
    localparam int unsigned EW = 2 * WIDTH + 2;

    bist_state_e   state_q, state_d;
    logic          clear, advance, dec_wait;
    logic [VW-1:0] vec;
    logic          wait_zero, last_vec;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [EW-1:0] err_count_q, err_count_d;
    logic [VW-1:0] first_fail_q, first_fail_d;
    logic          fail_seen_q, fail_seen_d;

    logic [MAX_W:0] gold_full;
    logic           mismatch;
    logic [EW-1:0]  err_inc;

    bist_vec_gen #(
        .VW            (VW),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_vec_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .advance   (advance),
        .dec_wait  (dec_wait),
        .vec       (vec),
        .wait_zero (wait_zero),
        .last_vec  (last_vec)
    );

    // Operands are zero-extended into the shared golden function, so its upper
    // result bits are zero and the full-width compare is exact.
    always_comb begin
        gold_full = golden_sum(MAX_W'(vec[WIDTH-1:0]), MAX_W'(vec[2*WIDTH-1:WIDTH]), vec[VW-1]);
        mismatch  = ((MAX_W + 1)'({cout_in, sum_in}) != gold_full);
        err_inc   = (err_count_q == '1) ? err_count_q : err_count_q + EW'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
            ST_SETTLE:        if (wait_zero) state_d = ST_CHECK;
            ST_CHECK:         state_d = last_vec ? ST_DONE : ST_SETTLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Counter controls and result register updates per state.
    always_comb begin
        clear        = 1'b0;
        advance      = 1'b0;
        dec_wait     = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear        = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                end
            end
            ST_SETTLE: begin
                dec_wait = !wait_zero;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_count_d = err_inc;
                    if (!fail_seen_q) begin
                        first_fail_d = vec;
                        fail_seen_d  = 1'b1;
                    end
                end
                if (last_vec) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_count_d == '0);
                end else begin
                    advance = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    assign b_out      = vec[WIDTH-1:0];
    assign a_out      = vec[2*WIDTH-1:WIDTH];
    assign cin_out    = vec[VW-1];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;
    assign fail_seen  = fail_seen_q;

endmodule
